// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package arb_pkg;

  // Arbiter sequencing: wait for a request, run the access, pulse completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  localparam int MEM_LATENCY_DEFAULT = 4;
  localparam int CNT_W               = 4;

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Access-latency down-counter: loaded at grant, counts down while the
// memory access runs, and flags when the final access cycle is reached.
module lat_counter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register, cleared asynchronously so an abandoned access leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one fixed-latency memory between an instruction
// fetch port and a data port. One transaction at a time: grant in IDLE,
// MEM_LATENCY access cycles in BUSY, a single completion cycle in RESP.
// Handshake: a requester raises req and holds it until its valid pulses;
// the valid pulse lasts one cycle and rdata is meaningful while it is high.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        stall
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

  arb_state_e  state_q;
  gnt_e        gnt_q;
  gnt_e        last_gnt_q;
  gnt_e        gnt_sel;
  logic        req_any;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;
  logic        mem_en_q;
  logic        mem_wr_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic [15:0] i_rdata_q;
  logic [15:0] d_rdata_q;
  logic        i_valid_q;
  logic        d_valid_q;

  // Data port wins unless both ask and data had the previous grant,
  // which keeps a continuously requesting data port from starving fetches.
  always_comb begin
    req_any = i_req | d_req;
    gnt_sel = GNT_I;
    if (d_req && !(i_req && (last_gnt_q == GNT_D))) begin
      gnt_sel = GNT_D;
    end
  end

  assign cnt_load = (state_q == IDLE) && req_any;
  assign cnt_dec  = (state_q == BUSY);

  lat_counter u_lat_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (LOAD_VAL),
    .zero_o     (cnt_zero)
  );

  // Arbiter FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_I;
      last_gnt_q  <= GNT_I;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            state_q    <= BUSY;
            gnt_q      <= gnt_sel;
            last_gnt_q <= gnt_sel;
            mem_en_q   <= 1'b1;
            if (gnt_sel == GNT_D) begin
              mem_wr_q    <= d_wr;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
            end else begin
              mem_wr_q    <= 1'b0;
              mem_addr_q  <= i_addr;
              mem_wdata_q <= '0;
            end
          end
        end
        BUSY: begin
          // Final access cycle: memory read data is stable now.
          if (cnt_zero) begin
            state_q  <= RESP;
            mem_en_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (gnt_q == GNT_D) begin
              d_valid_q <= 1'b1;
              if (!mem_wr_q) begin
                d_rdata_q <= mem_rdata;
              end
            end else begin
              i_valid_q <= 1'b1;
              i_rdata_q <= mem_rdata;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;

  // A requester is stalled from raising req until its completion pulse.
  assign stall = (i_req & ~i_valid_q) | (d_req & ~d_valid_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (latency 4, 1, 15) on one clock,
// a behavioural memory per instance, and a transaction-level reference
// model that predicts grants, latencies and returned data.
module tb_mem_arbiter;

  localparam int LAT [3] = '{4, 1, 15};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        i_req     [3];
  logic [15:0] i_addr    [3];
  logic [15:0] i_rdata   [3];
  logic        i_valid   [3];
  logic        d_req     [3];
  logic        d_wr      [3];
  logic [15:0] d_addr    [3];
  logic [15:0] d_wdata   [3];
  logic [15:0] d_rdata   [3];
  logic        d_valid   [3];
  logic        mem_en    [3];
  logic        mem_wr    [3];
  logic [15:0] mem_addr  [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];
  logic        stall     [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.MEM_LATENCY(LAT[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (i_req[g]),
      .i_addr    (i_addr[g]),
      .i_rdata   (i_rdata[g]),
      .i_valid   (i_valid[g]),
      .d_req     (d_req[g]),
      .d_wr      (d_wr[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_rdata   (d_rdata[g]),
      .d_valid   (d_valid[g]),
      .mem_en    (mem_en[g]),
      .mem_wr    (mem_wr[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .stall     (stall[g])
    );
  end

  // Initial memory contents (never written yet).
  function automatic logic [15:0] dflt(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hA5A5 : (a ^ 16'hC35A);
  endfunction

  // Behavioural memory: read data refreshed mid-cycle, writes on strobe.
  logic [15:0] env_mem [3][65536];
  bit          env_ok  [3][65536];
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      mem_rdata[k] <= env_ok[k][mem_addr[k]] ? env_mem[k][mem_addr[k]] : dflt(mem_addr[k]);
      if (mem_en[k] && mem_wr[k]) begin
        env_mem[k][mem_addr[k]] <= mem_wdata[k];
        env_ok[k][mem_addr[k]]  <= 1'b1;
      end
    end
  end

  // Reference model state.
  logic [15:0] ref_mem [3][65536];
  bit          ref_ok  [3][65536];
  int          age;
  bit          t_d, t_wr, last_d;
  logic [15:0] t_addr, t_wdata;
  logic [15:0] exp_i_rd, exp_d_rd;
  bit          d_known, cur_iv, cur_dv, i_done, d_done;
  bit          obs_log [$];
  int          cyc, v_cyc, en_cnt, wr_cnt, stall_cnt, start_cyc;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [15:0] ref_rd(input int k, input logic [15:0] a);
    return ref_ok[k][a] ? ref_mem[k][a] : dflt(a);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs == exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic reset_model();
    age = -1; last_d = 1'b0; exp_i_rd = '0; exp_d_rd = '0; d_known = 1'b1;
    cur_iv = 1'b0; cur_dv = 1'b0; i_done = 1'b0; d_done = 1'b0;
  endtask

  // Advance one clock and compare all registered outputs with the model.
  task automatic tick(input int k);
    int  l;
    bit  busy;
    l = LAT[k];
    @(posedge clk); #1;
    cyc++;
    if (age >= 0) age++;
    if (age == l + 2) age = -1;
    busy   = (age >= 1) && (age <= l);
    cur_iv = (age == l + 1) && !t_d;
    cur_dv = (age == l + 1) && t_d;
    chk1("mem_en", mem_en[k], busy);
    if (busy) begin
      chk16("mem_addr", mem_addr[k], t_addr);
      chk1("mem_wr", mem_wr[k], t_wr);
      if (t_wr) chk16("mem_wdata", mem_wdata[k], t_wdata);
    end
    chk1("i_valid", i_valid[k], cur_iv);
    chk1("d_valid", d_valid[k], cur_dv);
    chk1("valid_excl", i_valid[k] && d_valid[k], 1'b0);
    if (mem_en[k]) en_cnt++;
    if (mem_en[k] && mem_wr[k] && mem_addr[k] == 16'h0100) wr_cnt++;
    if (i_valid[k]) begin obs_log.push_back(1'b0); v_cyc = cyc; end
    if (d_valid[k]) begin obs_log.push_back(1'b1); v_cyc = cyc; end
    if (cur_iv) begin
      exp_i_rd = ref_rd(k, t_addr);
      i_done = 1'b1;
    end
    if (cur_dv) begin
      if (t_wr) begin
        ref_mem[k][t_addr] = t_wdata;
        ref_ok[k][t_addr]  = 1'b1;
        d_known = 1'b0;
      end else begin
        exp_d_rd = ref_rd(k, t_addr);
        d_known = 1'b1;
      end
      d_done = 1'b1;
    end
    chk16("i_rdata", i_rdata[k], exp_i_rd);
    if (d_known) chk16("d_rdata", d_rdata[k], exp_d_rd);
  endtask

  // Requesters: finished requests drop; in random mode new ones appear and
  // addresses/data wander every cycle (only the values at grant matter).
  task automatic drive(input int k, input bit rnd);
    if (i_done) begin i_req[k] = 1'b0; i_done = 1'b0; end
    if (d_done) begin d_req[k] = 1'b0; d_done = 1'b0; end
    if (rnd) begin
      if (!i_req[k] && $urandom_range(0, 2) == 0) i_req[k] = 1'b1;
      if (!d_req[k] && $urandom_range(0, 2) == 0) d_req[k] = 1'b1;
      i_addr[k]  = 16'($urandom_range(0, 31));
      d_addr[k]  = 16'($urandom_range(0, 31));
      d_wr[k]    = 1'($urandom_range(0, 1));
      d_wdata[k] = 16'($urandom);
    end
  endtask

  // Check stall for the inputs now applied; grant in model if arbiter idle.
  task automatic settle(input int k);
    #1;
    chk1("stall", stall[k], (i_req[k] && !cur_iv) || (d_req[k] && !cur_dv));
    if (stall[k]) stall_cnt++;
    if (age < 0 && (i_req[k] || d_req[k])) begin
      t_d     = d_req[k] && !(i_req[k] && last_d);
      t_wr    = t_d && d_wr[k];
      t_addr  = t_d ? d_addr[k] : i_addr[k];
      t_wdata = d_wdata[k];
      last_d  = t_d;
      age     = 0;
      start_cyc = cyc;
    end
  endtask

  task automatic cycle(input int k, input bit rnd);
    tick(k);
    drive(k, rnd);
    settle(k);
  endtask

  task automatic run_idle(input int k, input int max_c);
    int n;
    n = 0;
    while (!(age < 0 && !i_req[k] && !d_req[k]) && n < max_c) begin
      cycle(k, 1'b0);
      n++;
    end
    chk1("drain", age < 0 && !i_req[k] && !d_req[k], 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cyc = 0; v_cyc = 0; en_cnt = 0; wr_cnt = 0; stall_cnt = 0; start_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0; d_wr[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0;
    end
    reset_model();

    // Reset values on all instances.
    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk1("rst_mem_en", mem_en[k], 1'b0);
      chk1("rst_mem_wr", mem_wr[k], 1'b0);
      chk1("rst_i_valid", i_valid[k], 1'b0);
      chk1("rst_d_valid", d_valid[k], 1'b0);
      chk1("rst_stall", stall[k], 1'b0);
      chk16("rst_mem_addr", mem_addr[k], 16'h0000);
      chk16("rst_mem_wdata", mem_wdata[k], 16'h0000);
      chk16("rst_i_rdata", i_rdata[k], 16'h0000);
      chk16("rst_d_rdata", d_rdata[k], 16'h0000);
    end
    rst_n = 1'b1;

    // Simultaneous requests after reset: data first, then fetch.
    obs_log.delete();
    i_req[0] = 1'b1; i_addr[0] = 16'h0005;
    d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 16'h0006;
    settle(0);
    run_idle(0, 60);
    chk_int("s040_count", obs_log.size(), 2);
    if (obs_log.size() == 2) begin
      chk1("s040_first_d", obs_log[0], 1'b1);
      chk1("s040_second_i", obs_log[1], 1'b0);
    end

    // Single fetch with known memory word.
    en_cnt = 0;
    i_req[0] = 1'b1; i_addr[0] = 16'h0010;
    settle(0);
    run_idle(0, 40);
    chk16("s039_rdata", i_rdata[0], 16'hA5A5);
    chk_int("s039_en_cycles", en_cnt, 4);
    chk_int("s039_latency", v_cyc - start_cyc, 5);

    // Write then read back.
    wr_cnt = 0;
    d_req[0] = 1'b1; d_wr[0] = 1'b1; d_addr[0] = 16'h0100; d_wdata[0] = 16'h1234;
    settle(0);
    run_idle(0, 40);
    chk_int("s042_wr_cycles", wr_cnt, 4);
    d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 16'h0100;
    settle(0);
    run_idle(0, 40);
    chk16("s042_readback", d_rdata[0], 16'h1234);

    // Both held continuously: strict alternation, starting with fetch.
    obs_log.delete();
    i_req[0] = 1'b1; d_req[0] = 1'b1; d_wr[0] = 1'b0;
    settle(0);
    for (int c = 1; c <= 35; c++) begin
      tick(0);
      i_done = 1'b0; d_done = 1'b0;
      i_addr[0] = 16'($urandom_range(0, 31));
      d_addr[0] = 16'($urandom_range(0, 31));
      if (c == 35) begin i_req[0] = 1'b0; d_req[0] = 1'b0; end
      settle(0);
    end
    run_idle(0, 40);
    chk_int("s041_count", obs_log.size(), 6);
    if (obs_log.size() > 0) chk1("s041_first_i", obs_log[0], 1'b0);
    for (int i = 1; i < obs_log.size(); i++) chk1("s041_alternate", obs_log[i], !obs_log[i-1]);

    // Fetch request withdrawn before it could be granted.
    obs_log.delete();
    d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 16'h0007;
    settle(0);
    tick(0); i_req[0] = 1'b1; i_addr[0] = 16'h0003; settle(0);
    tick(0); i_req[0] = 1'b0; settle(0);
    run_idle(0, 40);
    for (int c = 0; c < 4; c++) cycle(0, 1'b0);
    chk_int("s031_grants", obs_log.size(), 1);

    // Reset in the second access cycle abandons the transaction.
    i_req[0] = 1'b1; i_addr[0] = 16'h0009;
    settle(0);
    tick(0);
    tick(0);
    rst_n = 1'b0;
    #1;
    chk1("s043_mem_en_async", mem_en[0], 1'b0);
    chk16("s043_mem_addr_async", mem_addr[0], 16'h0000);
    i_req[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk1("s043_no_valid_in_reset", i_valid[0], 1'b0);
    rst_n = 1'b1;
    reset_model();
    settle(0);
    obs_log.delete();
    for (int c = 0; c < 10; c++) cycle(0, 1'b0);
    chk_int("s043_no_valid_after", obs_log.size(), 0);
    i_req[0] = 1'b1; i_addr[0] = 16'h0010;
    settle(0);
    run_idle(0, 40);
    chk16("s043_next_rdata", i_rdata[0], 16'hA5A5);

    // Random traffic on the default-latency instance.
    for (int c = 0; c < 400; c++) cycle(0, 1'b1);
    run_idle(0, 60);

    // Latency extremes: exact latency and stall window, then random traffic.
    for (int k = 1; k < 3; k++) begin
      reset_model();
      stall_cnt = 0;
      i_req[k] = 1'b1; i_addr[k] = 16'h0003;
      settle(k);
      run_idle(k, 60);
      chk_int("s044_latency", v_cyc - start_cyc, LAT[k] + 1);
      chk_int("s044_stall_cycles", stall_cnt, LAT[k] + 1);
      chk16("s044_rdata", i_rdata[k], dflt(16'h0003));
      for (int c = 0; c < 200; c++) cycle(k, 1'b1);
      run_idle(k, 80);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
